// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a five-stage in-order pipeline.
// Resolves memory waits, taken branches and load-use hazards, and keeps stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_mem_read,
  input  logic             branch_taken,
  input  logic             EX_MEM_mem_req,
  input  logic             mem_ready,
  input  logic             halt_clear,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Value of the wait counter on the busy cycle that completes the timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_busy;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign mem_busy = EX_MEM_mem_req && !mem_ready;
  assign rs1_hit  = IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1);
  assign rs2_hit  = IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2);
  assign load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    MEM_WB_flush = 1'b0;

    if (state_q == ST_HALT) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
      wait_d       = '0;
      if (halt_clear) begin
        state_d = ST_RUN;
      end
    end else if (mem_busy) begin
      // Freeze everything up to MEM and drain a bubble into WB while memory is busy.
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
      if (state_q == ST_MEM_WAIT) begin
        wait_d  = wait_q + WAIT_W'(1);
        state_d = (wait_q == WAIT_LAST) ? ST_HALT : ST_MEM_WAIT;
      end else begin
        wait_d  = '0;
        state_d = ST_MEM_WAIT;
      end
    end else begin
      state_d = ST_RUN;
      wait_d  = '0;
      if (branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (IF_ID_flush || ID_EX_flush) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted       = (state_q == ST_HALT);
  assign state_o      = state_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule
